// File: rtl/addsub_pipeline.sv
// addsub_pipeline
//   A carry-pipelined adder/subtractor. Stage k resolves bit chunk k of the
//   operation. The carry out of stage k is registered and feeds stage k+1.
//   The upper operand bits ride along in skew registers until their chunk's
//   carry arrives. Finished low sum bits are carried forward, so the whole
//   result leaves the last stage in one cycle.
//
// Parameters
//   C_OPERAND_WIDTH  W : operand/sum width (1..64)
//   C_CHUNK_WIDTH    C : bits resolved per stage (1..W; C >= W gives N = 1)
//
// Ports
//   iclk       : clock, rising edge
//   irst       : synchronous active-high reset (clears valid, carry, sum, flags)
//   ice        : advance enable; 0 holds every register
//   ivalid     : ia/ib/isub form an operation this cycle
//   ia, ib     : operands (W bits)
//   isub       : 0 = A+B, 1 = A-B
//   ovalid     : osum/ocarry/ooverflow hold a result
//   osum       : result modulo 2^W
//   ocarry     : carry out of bit W-1 (subtract: 1 = no borrow)
//   ooverflow  : two's-complement signed overflow
//
// Handshake: ivalid/ovalid are plain valid qualifiers with no back-pressure.
// An operation is accepted at a rising edge where ice=1, irst=0 and ivalid=1.
// Its result is presented N enabled edges later, with ovalid=1.
module addsub_pipeline #(
  parameter int C_OPERAND_WIDTH = 8,
  parameter int C_CHUNK_WIDTH   = 2
) (
  input  logic                       iclk,
  input  logic                       irst,
  input  logic                       ice,
  input  logic                       ivalid,
  input  logic [C_OPERAND_WIDTH-1:0] ia,
  input  logic [C_OPERAND_WIDTH-1:0] ib,
  input  logic                       isub,
  output logic                       ovalid,
  output logic [C_OPERAND_WIDTH-1:0] osum,
  output logic                       ocarry,
  output logic                       ooverflow
);

  localparam int W = C_OPERAND_WIDTH;
  localparam int C = C_CHUNK_WIDTH;
  localparam int N = (W + C - 1) / C;

  for (genvar k = 0; k < N; k++) begin : stg
    // Bit range of this stage's chunk; the top chunk may be narrower.
    localparam int LO = k * C;
    localparam int HI = (((k + 1) * C) < W) ? ((k + 1) * C - 1) : (W - 1);
    localparam int CW = HI - LO + 1;
    // Operand bits arriving at this stage (bits LO..W-1), and bits left over
    // after this chunk that must be skewed on to later stages.
    localparam int IW = W - LO;
    localparam int RW = W - 1 - HI;

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [CW:0]   add;
    logic [HI:0]   sum_d;
    logic [HI:0]   sum_q;
    logic          carry_d;
    logic          carry_q;
    logic          valid_d;
    logic          valid_q;

    if (k == 0) begin : g_src
      // B is inverted here, once; the skew registers hold the effective B.
      // Stage 0 takes isub as its carry-in, which completes the two's
      // complement for a subtract.
      assign a_in = ia;
      assign b_in = isub ? ~ib : ib;
      assign c_in = isub;
      assign v_in = ivalid;
    end else begin : g_src
      assign a_in = stg[k-1].g_fwd.a_q;
      assign b_in = stg[k-1].g_fwd.b_q;
      assign c_in = stg[k-1].carry_q;
      assign v_in = stg[k-1].valid_q;
    end

    always_comb begin
      add     = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};
      carry_d = add[CW];
      valid_d = v_in;
    end

    // Completed low sum bits travel with the operation (deskew).
    if (k == 0) begin : g_sum
      assign sum_d = add[CW-1:0];
    end else begin : g_sum
      assign sum_d = {add[CW-1:0], stg[k-1].sum_q};
    end

    always_ff @(posedge iclk) begin
      if (irst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (ice) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < N - 1) begin : g_fwd
      // Skew registers for operand bits not yet added.
      logic [RW-1:0] a_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_d;
      logic [RW-1:0] b_q;

      always_comb begin
        a_d = a_in[IW-1:CW];
        b_d = b_in[IW-1:CW];
      end

      always_ff @(posedge iclk) begin
        if (irst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ice) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      // The top chunk holds both sign bits and the result sign, so the
      // overflow flag is formed here alongside the final sum.
      logic ovf_d;
      logic ovf_q;

      always_comb begin
        ovf_d = (a_in[IW-1] == b_in[IW-1]) && (add[CW-1] != a_in[IW-1]);
      end

      always_ff @(posedge iclk) begin
        if (irst) begin
          ovf_q <= 1'b0;
        end else if (ice) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign ovalid    = stg[N-1].valid_q;
  assign osum      = stg[N-1].sum_q;
  assign ocarry    = stg[N-1].carry_q;
  assign ooverflow = stg[N-1].g_last.ovf_q;

endmodule

// File: tb/tb_addsub_pipeline.sv
// tb_addsub_pipeline
//   Directed and random checks of addsub_pipeline. The main instance uses
//   W=8, C=2 (N=4). Three side instances cover W=3/C=1, W=8/C=3 and W=8/C=8.
module tb_addsub_pipeline;

  localparam int N_MAIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       vld = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic       ovalid;
  logic [7:0] osum;
  logic       ocarry;
  logic       oovf;

  addsub_pipeline #(.C_OPERAND_WIDTH(8), .C_CHUNK_WIDTH(2)) dut (
    .iclk(clk), .irst(rst), .ice(ce), .ivalid(vld), .ia(a), .ib(b), .isub(sub),
    .ovalid(ovalid), .osum(osum), .ocarry(ocarry), .ooverflow(oovf)
  );

  // Side instances for the parameter sweep, sharing one stimulus set.
  logic       sw_ce  = 1'b1;
  logic       sw_vld = 1'b0;
  logic       sw_sub = 1'b0;
  logic [7:0] sw_a   = 8'h00;
  logic [7:0] sw_b   = 8'h00;
  logic [2:0] sw_a3  = 3'd0;
  logic [2:0] sw_b3  = 3'd0;

  logic       v3, c3, f3;
  logic [2:0] s3;
  logic       v83, c83, f83;
  logic [7:0] s83;
  logic       v88, c88, f88;
  logic [7:0] s88;

  addsub_pipeline #(.C_OPERAND_WIDTH(3), .C_CHUNK_WIDTH(1)) dut_w3c1 (
    .iclk(clk), .irst(rst), .ice(sw_ce), .ivalid(sw_vld), .ia(sw_a3), .ib(sw_b3),
    .isub(sw_sub), .ovalid(v3), .osum(s3), .ocarry(c3), .ooverflow(f3)
  );
  addsub_pipeline #(.C_OPERAND_WIDTH(8), .C_CHUNK_WIDTH(3)) dut_w8c3 (
    .iclk(clk), .irst(rst), .ice(sw_ce), .ivalid(sw_vld), .ia(sw_a), .ib(sw_b),
    .isub(sw_sub), .ovalid(v83), .osum(s83), .ocarry(c83), .ooverflow(f83)
  );
  addsub_pipeline #(.C_OPERAND_WIDTH(8), .C_CHUNK_WIDTH(8)) dut_w8c8 (
    .iclk(clk), .irst(rst), .ice(sw_ce), .ivalid(sw_vld), .ia(sw_a), .ib(sw_b),
    .isub(sw_sub), .ovalid(v88), .osum(s88), .ocarry(c88), .ooverflow(f88)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       vld;
    logic       chk;   // compare data fields (0 for bubble slots)
    logic       c;
    logic       ovf;
    logic [7:0] sum;
  } slot_t;

  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic slot_t model(input logic [7:0] xa, input logic [7:0] xb,
                                  input logic xs, input logic xv);
    slot_t r;
    int ua, ub, ur, sa, sb, sr;
    ua = int'(xa);
    ub = int'(xb);
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    if (xs) begin
      ur  = ua - ub;
      sr  = sa - sb;
      r.c = (ua >= ub);
    end else begin
      ur  = ua + ub;
      sr  = sa + sb;
      r.c = (ur > 255);
    end
    r.sum = ur[7:0];
    r.ovf = (sr > 127) || (sr < -128);
    r.vld = xv;
    r.chk = xv;
    return r;
  endfunction

  // One clock of the main instance: inputs are already driven.
  // Outputs are sampled 1 time unit after the edge.
  task automatic step(input string name);
    logic [15:0] prev;
    slot_t       e;
    prev = {5'd0, ovalid, ocarry, oovf, osum};
    @(posedge clk);
    #1;
    if (rst) begin
      // Whatever was in flight is gone. N-1 all-zero slots precede the
      // first operation accepted after reset.
      check({name, "_reset"}, {5'd0, ovalid, ocarry, oovf, osum}, 16'h0000);
      exp_q.delete();
      for (int i = 0; i < N_MAIN - 1; i++) exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end else if (ce) begin
      exp_q.push_back(model(a, b, sub, vld));
      if (exp_q.size() >= N_MAIN) begin
        e = exp_q.pop_front();
        check({name, "_ovalid"}, {15'd0, ovalid}, {15'd0, e.vld});
        if (e.chk)
          check({name, "_result"}, {6'd0, ocarry, oovf, osum}, {6'd0, e.c, e.ovf, e.sum});
      end
    end else begin
      check({name, "_stall_hold"}, {5'd0, ovalid, ocarry, oovf, osum}, prev);
    end
  endtask

  // ---------------- directed vector tables ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       c;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] a8;
    logic [7:0] b8;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       sub;
    logic [9:0] e8;   // {c, ovf, sum}
    logic [4:0] e3;   // {c, ovf, sum}
  } swv_t;

  vec_t vecs[10];
  swv_t swv[4];

  initial begin
    // Hand-computed results, W=8.
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[9] = '{8'hC0, 8'h40, 1'b1, 8'h80, 1'b1, 1'b0};

    // Sweep vectors: W=8 results and the W=3 analogues.
    swv[0] = '{8'hFF, 8'h01, 3'd7, 3'd1, 1'b0, {1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 3'd0}};
    swv[1] = '{8'h7F, 8'h01, 3'd3, 3'd1, 1'b0, {1'b0, 1'b1, 8'h80}, {1'b0, 1'b1, 3'd4}};
    swv[2] = '{8'h80, 8'h01, 3'd4, 3'd1, 1'b1, {1'b1, 1'b1, 8'h7F}, {1'b1, 1'b1, 3'd3}};
    swv[3] = '{8'h00, 8'h01, 3'd0, 3'd1, 1'b1, {1'b0, 1'b0, 8'hFF}, {1'b0, 1'b0, 3'd7}};

    // ---- reset held 2 cycles with ivalid=1: nothing accepted ----
    rst = 1'b1; ce = 1'b1; vld = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0; vld = 1'b0; a = 8'h00; b = 8'h00;
    for (int i = 0; i < N_MAIN; i++) step("post_reset");

    // ---- directed table, back to back, then flushed ----
    for (int i = 0; i < 10; i++) begin
      vld = 1'b1; a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub;
      step("vec");
    end
    vld = 1'b0;
    for (int i = 0; i < N_MAIN; i++) step("vec_flush");
    // Independent table cross-check: the table entries against the bench model.
    for (int i = 0; i < 10; i++) begin
      slot_t m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1);
      check("table_vs_model", {6'd0, m.c, m.ovf, m.sum}, {6'd0, vecs[i].c, vecs[i].ovf, vecs[i].sum});
    end

    // ---- directed ripple vector checked at exact latency ----
    vld = 1'b1; a = 8'hFF; b = 8'h01; sub = 1'b0;
    @(posedge clk); #1;
    vld = 1'b0;
    for (int j = 1; j <= N_MAIN; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      check("ripple_latency_valid", {15'd0, ovalid}, {15'd0, (j == N_MAIN)});
    end
    check("ripple_result", {6'd0, ocarry, oovf, osum}, {6'd0, 1'b1, 1'b0, 8'h00});
    // Re-sync the scoreboard with a reset (this also checks the outputs clear).
    rst = 1'b1; step("resync");
    rst = 1'b0;

    // ---- stall mid-stream with valid data in flight ----
    for (int i = 0; i < 12; i++) begin
      ce  = !(i >= 5 && i < 8);
      vld = 1'b1; a = 8'(i * 37 + 5); b = 8'(i * 11 + 200); sub = i[0];
      step("stall_stream");
    end
    ce = 1'b1; vld = 1'b0;
    for (int i = 0; i < N_MAIN; i++) step("stall_flush");

    // ---- random streaming with gaps and a 3-cycle stall ----
    for (int i = 0; i < 40003; i++) begin
      ce  = !(i >= 20000 && i < 20003);
      vld = ($urandom_range(0, 3) != 0);
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sub = 1'($urandom_range(0, 1));
      step("stream");
    end
    ce = 1'b1; vld = 1'b0;
    for (int i = 0; i < N_MAIN; i++) step("stream_flush");

    // ---- reset with 3 valid operations in flight (ice=0 at the reset edge) ----
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; a = 8'hF0 + 8'(i); b = 8'h21; sub = 1'b0;
      step("pre_reset_ops");
    end
    rst = 1'b1; ce = 1'b0; vld = 1'b1;
    step("midstream_reset");
    rst = 1'b0; ce = 1'b1; vld = 1'b0;
    for (int i = 0; i < N_MAIN + 2; i++) step("after_midstream_reset");

    // ---- parameter sweep: W=3/C=1 (N=3), W=8/C=3 (N=3), W=8/C=8 (N=1) ----
    for (int i = 0; i < 4; i++) begin
      sw_vld = 1'b1; sw_sub = swv[i].sub;
      sw_a = swv[i].a8; sw_b = swv[i].b8; sw_a3 = swv[i].a3; sw_b3 = swv[i].b3;
      for (int j = 1; j <= 4; j++) begin
        @(posedge clk); #1;
        sw_vld = 1'b0;
        check("w3c1_valid", {15'd0, v3},  {15'd0, (j == 3)});
        check("w8c3_valid", {15'd0, v83}, {15'd0, (j == 3)});
        check("w8c8_valid", {15'd0, v88}, {15'd0, (j == 1)});
        if (j == 3) begin
          check("w3c1_result", {11'd0, c3, f3, s3},    {11'd0, swv[i].e3});
          check("w8c3_result", {6'd0, c83, f83, s83}, {6'd0, swv[i].e8});
        end
        if (j == 1)
          check("w8c8_result", {6'd0, c88, f88, s88}, {6'd0, swv[i].e8});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
